// File: rtl/serializer_p.sv
// serializer_p: DATA_W-bit parallel words in over valid/ready, 1-bit serial stream out.
// A one-word hold buffer lets consecutive words stream with no idle gap.
// Each serial bit lasts DIV clocks.
module serializer_p #(
   parameter int DATA_W    = 32,
   parameter int DIV       = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              ser_out,
   output logic              bit_stb,
   output logic              frame_start,
   output logic              busy
);

   localparam int BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);
   localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_full;
   logic [BIT_CW-1:0] r_bit_cnt;
   logic [DIV_CW-1:0] r_div_cnt;
   logic              r_bit_stb;
   logic              r_frame_start;

   logic              w_in_shift;
   logic              w_xfer;
   logic              w_wrap;
   logic              w_last;
   logic              w_eow;
   logic              w_load;
   logic              w_advance;
   logic              w_to_hold;
   logic              w_hold_take;
   logic [DATA_W-1:0] w_load_word;
   logic [DATA_W-1:0] w_shift_adv;

   // The shifter always presents the bit on the wire at its leading end;
   // advancing moves the next bit into that position and back-fills zeros.
   generate
      if (MSB_FIRST != 0) begin : g_msb
         assign w_shift_adv = {r_shift[DATA_W-2:0], 1'b0};
         assign ser_out     = r_shift[DATA_W-1];
      end else begin : g_lsb
         assign w_shift_adv = {1'b0, r_shift[DATA_W-1:1]};
         assign ser_out     = r_shift[0];
      end
   endgenerate

   assign in_ready    = !r_hold_full;
   assign bit_stb     = r_bit_stb;
   assign frame_start = r_frame_start;
   assign busy        = (r_state == S_SHIFT);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: start on an accepted word, stop when a word ends with nothing queued
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_xfer) w_state_next = S_SHIFT;
         S_SHIFT: if (w_eow && !w_load) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Control decode: bit timing, end of word, and where the next word comes from
   always_comb begin
      w_in_shift  = (r_state == S_SHIFT);
      w_xfer      = in_valid && !r_hold_full;
      w_wrap      = (r_div_cnt == DIV_LAST);
      w_last      = (r_bit_cnt == BIT_LAST);
      w_eow       = w_in_shift && w_wrap && w_last;
      // A held word has priority; otherwise a word offered right now bypasses the hold buffer
      w_load      = (!w_in_shift && w_xfer) || (w_eow && (r_hold_full || w_xfer));
      w_advance   = w_in_shift && w_wrap && !w_last;
      w_to_hold   = w_in_shift && w_xfer && !w_eow;
      w_hold_take = w_eow && r_hold_full;
      w_load_word = r_hold_full ? r_hold : in_data;
   end

   // Shifter, bit/div counters and the single-cycle strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_div_cnt     <= '0;
         r_bit_stb     <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_bit_stb     <= 1'b0;
         r_frame_start <= 1'b0;
         if (w_load) begin
            r_shift       <= w_load_word;
            r_bit_cnt     <= '0;
            r_div_cnt     <= '0;
            r_bit_stb     <= 1'b1;
            r_frame_start <= 1'b1;
         end else if (w_advance) begin
            r_shift   <= w_shift_adv;
            r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
            r_div_cnt <= '0;
            r_bit_stb <= 1'b1;
         end else if (w_eow) begin
            // Word finished with nothing to follow: park the line low
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
         end else if (w_in_shift) begin
            r_div_cnt <= r_div_cnt + DIV_CW'(1);
         end
      end
   end

   // One-word hold buffer, filled while shifting and drained at end of word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (w_to_hold) begin
         r_hold      <= in_data;
         r_hold_full <= 1'b1;
      end else if (w_hold_take) begin
         r_hold_full <= 1'b0;
      end
   end

endmodule
